// File: rtl/serial_fa_sequencer.sv
// Bit-serial adder controller: streams operand bit pairs LSB-first to an external
// 1-bit full adder and assembles its sum. Optional subtract mode: SERIAL_FA_SUB_EN.
module serial_fa_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
`ifdef SERIAL_FA_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_s_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic [WIDTH-1:0] w_s_next;
    logic             w_unused_lsb;

    // Operand B and initial carry as loaded; subtract is A + ~B + 1
`ifdef SERIAL_FA_SUB_EN
    assign w_b_load = sub ? ~b_in : b_in;
    assign w_c_load = sub ? 1'b1  : cin;
`else
    assign w_b_load = b_in;
    assign w_c_load = cin;
`endif

    assign w_s_next     = {fa_sum, r_s_sh[WIDTH-1:1]};
    assign w_unused_lsb = r_s_sh[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= a_in;
                        r_b_sh  <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                        r_s_sh  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_s_sh  <= w_s_next;
                    r_carry <= fa_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // Final bit: capture result and carry-out from the cell
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_sum   <= w_s_next;
                        r_cout  <= fa_cout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Cell inputs come from registers only; gated to zero outside RUN
    assign fa_a     = r_busy & r_a_sh[0];
    assign fa_b     = r_busy & r_b_sh[0];
    assign fa_c     = r_busy & r_carry;

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum_out  = r_sum;
    assign cout_out = r_cout;

endmodule
